// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back cache with tree-PLRU replacement.
// Hits respond combinationally; misses write back a dirty victim, then fill.
module cache_nway_wb #(
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int num_ways = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                mem_address,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [2**s_offset-1:0]     mem_byte_enable,
  input  logic [8*2**s_offset-1:0]   mem_wdata,
  output logic [8*2**s_offset-1:0]   mem_rdata,
  output logic                       mem_resp,
  output logic [31:0]                pmem_address,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [8*2**s_offset-1:0]   pmem_wdata,
  input  logic [8*2**s_offset-1:0]   pmem_rdata,
  input  logic                       pmem_resp,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);

  localparam int s_tag    = 32 - s_offset - s_index;
  localparam int s_line   = 8 * 2**s_offset;
  localparam int s_mask   = 2**s_offset;
  localparam int num_sets = 2**s_index;
  localparam int s_lvl    = $clog2(num_ways);

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    ALLOC
  } state_t;

  state_t state_q, state_d;

  logic [s_line-1:0] data_q [num_ways][num_sets];
  logic [s_tag-1:0]  tag_q  [num_ways][num_sets];
  logic [num_sets-1:0][num_ways-1:0] valid_q;
  logic [num_sets-1:0][num_ways-1:0] dirty_q;
  logic [num_sets-1:0][num_ways-2:0] plru_q;

  logic [s_lvl-1:0] vict_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;
  logic             pend_q;

  logic [s_tag-1:0]   tag;
  logic [s_index-1:0] idx;
  logic               req;
  logic               hit;
  logic [s_lvl-1:0]   hit_way;
  logic               any_inv;
  logic [s_lvl-1:0]   inv_way;
  logic [s_lvl-1:0]   vict_pick;
  logic               need_wb;
  logic               acc_hit;
  logic               wr_hit;
  logic               miss_start;
  logic               fill;
  logic               wb_done;
  logic               unused_off;

  assign tag        = mem_address[31:s_offset+s_index];
  assign idx        = mem_address[s_offset+s_index-1:s_offset];
  assign unused_off = ^mem_address[s_offset-1:0];
  assign req        = mem_read | mem_write;

  // Heap-ordered tree, node 1 is the root; bit 0 points to the lower half.
  function automatic logic [s_lvl-1:0] plru_victim(
    input logic [num_ways-2:0] t
  );
    logic [num_ways-1:0] tt;
    logic [s_lvl-1:0]    n;
    logic [s_lvl-1:0]    w;
    logic                b;
    tt = {t, 1'b0};
    n  = s_lvl'(1);
    w  = '0;
    for (int l = 0; l < s_lvl; l++) begin
      b = tt[n];
      w = (w << 1) | s_lvl'(b);
      n = (n << 1) | s_lvl'(b);
    end
    return w;
  endfunction

  function automatic logic [num_ways-2:0] plru_upd(
    input logic [num_ways-2:0] t,
    input logic [s_lvl-1:0]    way
  );
    logic [num_ways-1:0] tt;
    logic [s_lvl-1:0]    n;
    logic [s_lvl-1:0]    ww;
    logic                b;
    tt = {t, 1'b0};
    n  = s_lvl'(1);
    ww = way;
    for (int l = 0; l < s_lvl; l++) begin
      b     = ww[s_lvl-1];
      tt[n] = ~b;
      n     = (n << 1) | s_lvl'(b);
      ww    = ww << 1;
    end
    return tt[num_ways-1:1];
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = s_lvl'(w);
      end
    end
  end

  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        any_inv = 1'b1;
        inv_way = s_lvl'(w);
      end
    end
    vict_pick = any_inv ? inv_way : plru_victim(plru_q[idx]);
    need_wb   = !any_inv && dirty_q[idx][vict_pick];
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, idx, {s_offset{1'b0}}};
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) mem_resp = 1'b1;
          else     state_d  = need_wb ? WBACK : ALLOC;
        end
      end
      WBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[vict_q][idx], idx, {s_offset{1'b0}}};
        if (pmem_resp) state_d = ALLOC;
      end
      ALLOC: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rdata  = data_q[hit_way][idx];
  assign pmem_wdata = data_q[vict_q][idx];
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  assign acc_hit    = mem_resp;
  assign wr_hit     = acc_hit & mem_write;
  assign miss_start = (state_q == IDLE) & req & ~hit;
  assign fill       = (state_q == ALLOC) & pmem_resp;
  assign wb_done    = (state_q == WBACK) & pmem_resp;

  // Data and tags need no reset: valid is cleared, so nothing can hit them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[vict_q][idx] <= pmem_rdata;
      tag_q[vict_q][idx]  <= tag;
    end else if (wr_hit) begin
      for (int b = 0; b < s_mask; b++) begin
        if (mem_byte_enable[b])
          data_q[hit_way][idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      plru_q     <= '0;
      vict_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        vict_q <= vict_pick;
        pend_q <= 1'b1;
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      // The completing hit of a miss is not a second event.
      if (acc_hit) begin
        pend_q         <= 1'b0;
        plru_q[idx]    <= plru_upd(plru_q[idx], hit_way);
        if (!pend_q && hit_cnt_q != 32'hFFFF_FFFF)
          hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (wr_hit)  dirty_q[idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[idx][vict_q]  <= 1'b0;
      if (fill) begin
        valid_q[idx][vict_q] <= 1'b1;
        dirty_q[idx][vict_q] <= 1'b0;
        plru_q[idx]          <= plru_upd(plru_q[idx], vict_q);
      end
    end
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb with a two-cycle line memory model.
// Expected data comes from a fixed address-derived fill pattern.
module tb_cache_nway_wb;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_pass = 0;
  int n_chk  = 0;

  int           rd_cnt = 0;
  int           wb_cnt = 0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;
  logic         both_seen = 1'b0;
  int           mcnt = 0;

  cache_nway_wb dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A00_0000}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory answers two cycles after a strobe appears.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_read && pmem_write) both_seen = 1'b1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mcnt      = 0;
      end else if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt == 2) begin
          mcnt      = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            wb_cnt++;
            wb_addr = pmem_address;
            wb_data = pmem_wdata;
          end else begin
            rd_cnt++;
            rd_addr    = pmem_address;
            pmem_rdata = pat(pmem_address);
          end
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic wr,
                     input logic [31:0] be, input logic [255:0] wd,
                     output logic [255:0] rd, output int lat);
    @(posedge clk);
    #1;
    mem_address     = a;
    mem_read        = ~wr;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        rd  = mem_rdata;
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [255:0] rd;
  logic [255:0] merged;
  int           lat;
  int           rc0;
  int           wc0;
  logic         seen;

  initial begin
    rst             = 1'b0;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    merged          = pat(32'h040);
    merged[31:0]    = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("rst_hit",   hit_count, 0);
    chk("rst_miss",  miss_count, 0);
    chk("rst_resp",  mem_resp, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    rst = 1'b1;

    // cold miss then hit
    wc0 = wb_cnt;
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t1_lat",   lat, 3);
    chk("t1_data",  rd, pat(32'h040));
    chk("t1_raddr", rd_addr, 32'h040);
    chk("t1_nowb",  wb_cnt, wc0);
    chk("t1_miss",  miss_count, 1);
    chk("t1_hit",   hit_count, 0);
    rc0 = rd_cnt;
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t2_lat",   lat, 0);
    chk("t2_data",  rd, pat(32'h040));
    chk("t2_nomem", rd_cnt, rc0);
    chk("t2_hit",   hit_count, 1);

    // write hit with byte mask
    req(32'h040, 1'b1, 32'h0000_000F, {224'h0, 32'hDEADBEEF}, rd, lat);
    chk("t3_wlat", lat, 0);
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t3_rlat", lat, 0);
    chk("t3_data", rd, merged);
    chk("t3_hit",  hit_count, 3);
    chk("t3_miss", miss_count, 1);

    // PLRU victim choice, clean eviction
    do_reset();
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t4_f0", lat, 3);
    req(32'h240, 1'b0, '0, '0, rd, lat);
    chk("t4_f1", lat, 3);
    req(32'h440, 1'b0, '0, '0, rd, lat);
    chk("t4_f2", lat, 3);
    req(32'h640, 1'b0, '0, '0, rd, lat);
    chk("t4_f3", lat, 3);
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t4_h0", lat, 0);
    wc0 = wb_cnt;
    req(32'h840, 1'b0, '0, '0, rd, lat);
    chk("t4_evlat", lat, 3);
    chk("t4_raddr", rd_addr, 32'h840);
    chk("t4_nowb",  wb_cnt, wc0);
    chk("t4_data",  rd, pat(32'h840));
    req(32'h440, 1'b0, '0, '0, rd, lat);
    chk("t4_440miss", lat, 3);
    req(32'h640, 1'b0, '0, '0, rd, lat);
    chk("t4_640hit", lat, 0);
    chk("t4_miss", miss_count, 6);
    chk("t4_hit",  hit_count, 2);

    // dirty eviction
    do_reset();
    wc0 = wb_cnt;
    req(32'h040, 1'b1, 32'h0000_000F, {224'h0, 32'hDEADBEEF}, rd, lat);
    chk("t5_wmiss", lat, 3);
    req(32'h240, 1'b0, '0, '0, rd, lat);
    req(32'h440, 1'b0, '0, '0, rd, lat);
    req(32'h640, 1'b0, '0, '0, rd, lat);
    chk("t5_f3", lat, 3);
    req(32'h840, 1'b0, '0, '0, rd, lat);
    chk("t5_lat",   lat, 6);
    chk("t5_wbcnt", wb_cnt, wc0 + 1);
    chk("t5_wbaddr", wb_addr, 32'h040);
    chk("t5_wbdata", wb_data, merged);
    chk("t5_raddr", rd_addr, 32'h840);
    chk("t5_data",  rd, pat(32'h840));

    // reset during allocate
    do_reset();
    @(posedge clk);
    #1;
    mem_address = 32'h040;
    mem_read    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_alloc", seen, 1);
    rst = 1'b0;
    #1;
    chk("t6_pread", pmem_read, 0);
    chk("t6_miss",  miss_count, 0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req(32'h040, 1'b0, '0, '0, rd, lat);
    chk("t6_relat", lat, 3);
    chk("t6_remiss", miss_count, 1);
    chk("t6_data",  rd, pat(32'h040));

    chk("no_both_strobes", both_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
